// File: rtl/area_stats_pkg.sv
// rtl/area_stats_pkg.sv - shared widths, polarity and FSM state type for area_stats
package area_stats_pkg;

    localparam int   DEF_NCH   = 4;
    localparam int   DEF_CNT_W = 24;
    localparam int   DEF_X_W   = 12;
    localparam int   DEF_Y_W   = 12;
    localparam logic DEF_POL   = 1'b0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_t;

    // Index width for NCH channels, never narrower than one bit.
    function automatic int best_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/area_cnt_ch.sv
// rtl/area_cnt_ch.sv - one channel's saturating area accumulator with sticky sat flag
module area_cnt_ch
    import area_stats_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             pixelclk,
    input  logic             rst_n,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_sat;
    logic             w_at_max;

    // Outputs include this cycle's increment so a frame close can latch it.
    assign w_at_max = (r_cnt == CNT_MAX);
    assign o_cnt    = (i_inc && !w_at_max) ? r_cnt + 1'b1 : r_cnt;
    assign o_sat    = r_sat | (i_inc & w_at_max);

    always_ff @(posedge pixelclk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else if (i_clr) begin
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else begin
            r_cnt <= o_cnt;
            r_sat <= o_sat;
        end
    end

endmodule

// File: rtl/area_stats.sv
// rtl/area_stats.sv - per-frame multi-channel ROI area counter with latched results and argmax
module area_stats
    import area_stats_pkg::*;
#(
    parameter int   NCH   = DEF_NCH,
    parameter int   CNT_W = DEF_CNT_W,
    parameter int   X_W   = DEF_X_W,
    parameter int   Y_W   = DEF_Y_W,
    parameter logic POL   = DEF_POL
) (
    input  logic                      pixelclk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [NCH-1:0]            i_mask,
    input  logic                      i_hs,
    input  logic                      i_vs,
    input  logic                      i_de,
    input  logic [X_W-1:0]            roi_x0,
    input  logic [X_W-1:0]            roi_x1,
    input  logic [Y_W-1:0]            roi_y0,
    input  logic [Y_W-1:0]            roi_y1,
    output logic [NCH*CNT_W-1:0]      o_area,
    output logic [NCH-1:0]            o_sat,
    output logic                      o_valid,
    output logic [best_w(NCH)-1:0]    o_best,
    output logic                      o_best_valid
);

    localparam int BW = best_w(NCH);

    logic             r_vs, r_de;
    logic [X_W-1:0]   r_x, r_x0, r_x1;
    logic [Y_W-1:0]   r_y, r_y0, r_y1;
    logic             w_vs_fall, w_de_fall, w_in_roi, w_qual;
    logic             w_unused_hs;

    logic [NCH-1:0]       w_inc;
    logic [NCH*CNT_W-1:0] w_cnt;
    logic [NCH-1:0]       w_sat;

    logic [NCH*CNT_W-1:0] r_area;
    logic [NCH-1:0]       r_sat;
    logic                 r_valid;

    scan_state_t      r_state, w_state_nxt;
    logic [BW-1:0]    r_idx, w_idx_nxt, w_idx, w_sel;
    logic [BW-1:0]    r_run, w_run_nxt, r_best, w_best_nxt;
    logic [CNT_W-1:0] r_max, w_max_nxt, w_cur;
    logic             r_best_valid, w_best_valid_nxt, w_take, w_step;

    assign w_unused_hs = i_hs;
    assign w_vs_fall   = r_vs & ~i_vs;
    assign w_de_fall   = r_de & ~i_de;
    assign w_in_roi    = (r_x >= r_x0) && (r_x <= r_x1) && (r_y >= r_y0) && (r_y <= r_y1);
    assign w_qual      = en & i_de & w_in_roi;

    // Coordinates of the pixel presented this cycle, plus the ROI shadow for the running frame.
    always_ff @(posedge pixelclk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs <= 1'b0;
            r_de <= 1'b0;
            r_x  <= '0;
            r_y  <= '0;
            r_x0 <= '0;
            r_x1 <= '1;
            r_y0 <= '0;
            r_y1 <= '1;
        end else begin
            r_vs <= i_vs;
            r_de <= i_de;
            r_x  <= i_de ? r_x + 1'b1 : '0;
            if (w_vs_fall) begin
                r_y  <= '0;
                r_x0 <= roi_x0;
                r_x1 <= roi_x1;
                r_y0 <= roi_y0;
                r_y1 <= roi_y1;
            end else if (w_de_fall) begin
                r_y <= r_y + 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        assign w_inc[k] = w_qual & (i_mask[k] == POL);
        area_cnt_ch #(.CNT_W(CNT_W)) u_cnt (
            .pixelclk (pixelclk),
            .rst_n    (rst_n),
            .i_inc    (w_inc[k]),
            .i_clr    (w_vs_fall),
            .o_cnt    (w_cnt[k*CNT_W +: CNT_W]),
            .o_sat    (w_sat[k])
        );
    end

    always_ff @(posedge pixelclk or negedge rst_n) begin
        if (!rst_n) begin
            r_area  <= '0;
            r_sat   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_vs_fall;
            if (w_vs_fall) begin
                r_area <= w_cnt;
                r_sat  <= w_sat;
            end
        end
    end

    // The o_valid cycle itself evaluates channel 0, so the result lands NCH cycles later.
    assign w_step = r_valid | (r_state == ST_SCAN);
    assign w_idx  = r_valid ? '0 : r_idx;
    assign w_cur  = r_area[w_idx*CNT_W +: CNT_W];
    assign w_take = (w_idx == '0) || (w_cur > r_max);
    assign w_sel  = w_take ? w_idx : r_run;

    always_comb begin
        w_state_nxt      = r_state;
        w_idx_nxt        = r_idx;
        w_max_nxt        = r_max;
        w_run_nxt        = r_run;
        w_best_nxt       = r_best;
        w_best_valid_nxt = 1'b0;
        if (w_step) begin
            if (w_take) begin
                w_max_nxt = w_cur;
            end
            w_run_nxt = w_sel;
            if (w_idx == BW'(NCH - 1)) begin
                w_best_nxt       = w_sel;
                w_best_valid_nxt = 1'b1;
                w_state_nxt      = ST_IDLE;
            end else begin
                w_idx_nxt   = w_idx + 1'b1;
                w_state_nxt = ST_SCAN;
            end
        end
    end

    always_ff @(posedge pixelclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_max        <= '0;
            r_run        <= '0;
            r_best       <= '0;
            r_best_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_max        <= w_max_nxt;
            r_run        <= w_run_nxt;
            r_best       <= w_best_nxt;
            r_best_valid <= w_best_valid_nxt;
        end
    end

    assign o_area       = r_area;
    assign o_sat        = r_sat;
    assign o_valid      = r_valid;
    assign o_best       = r_best;
    assign o_best_valid = r_best_valid;

endmodule

// File: doc/area_stats.md
Name: area_stats

Overview:
Per-frame multi-channel pixel-area accumulator for the ISP binary path, generalising the single-mask area counter.
- Counts, per channel, the pixels whose mask bit equals a programmable polarity inside a programmable ROI.
- Latches all counts at frame end and raises a one-cycle valid strobe.
- Runs a sequential argmax so downstream fruit-classification logic gets the dominant channel index.

Parameters:
NCH, 4, number of binary mask channels
CNT_W, 24, per-channel area counter width
X_W, 12, column counter / ROI x width
Y_W, 12, row counter / ROI y width
POL, 0, mask value counted as "object" (0 = count i_mask bit low)

Ports:
pixelclk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
en  in  1  counting enable
i_mask  in  NCH  per-channel binary pixel
i_hs  in  1  line sync (not used for counting)
i_vs  in  1  frame sync, active high; falling edge = frame boundary
i_de  in  1  active-pixel qualifier
roi_x0, roi_x1  in  X_W  inclusive ROI columns
roi_y0, roi_y1  in  Y_W  inclusive ROI rows
o_area  out  NCH*CNT_W  latched counts, channel k at bits [k*CNT_W +: CNT_W]
o_sat  out  NCH  channel k saturated in latched frame
o_valid  out  1  one-cycle pulse, o_area/o_sat updated
o_best  out  clog2(NCH) max 1  channel with largest latched area
o_best_valid  out  1  one-cycle pulse, o_best updated

Behaviour:
- Reset: every output 0; accumulators, x/y counters, shadow ROI and FSM cleared; FSM = IDLE.
- vs_r registers i_vs. vs_fall = vs_r & ~i_vs.
- Coordinates:
  - x increments each i_de cycle and clears on i_de low.
  - y increments on each i_de falling edge and clears on vs_fall.
  - First active pixel of a frame is (0,0).
- ROI shadowing: ROI inputs are copied into shadow registers on vs_fall and apply to the following frame. Reset loads shadow with x0=y0=0 and x1=y1=all-ones (full frame). If x0>x1 or y0>y1, nothing is counted.
- Count condition for channel k: en & i_de & i_mask[k]==POL & x0<=x<=x1 & y0<=y<=y1.
  - Accumulator increments by 1.
  - Saturates at 2^CNT_W-1 and sets the sticky per-channel sat flag.
  - en low holds accumulators; frame latching still occurs.
- Frame latch on a vs_fall cycle:
  - o_area <= accumulator value including that cycle's qualifying pixel, if any.
  - o_sat <= sticky sat including that pixel's saturation.
  - Accumulators and sat flags clear, so the next cycle counts from 0.
  - o_valid = 1 on the following cycle only. Latency: the vs_fall edge updates outputs, which are visible the next cycle.
- Argmax FSM:
  - IDLE --o_valid--> SCAN.
  - SCAN: idx=0..NCH-1, one channel per cycle.
  - Strict > compare against the running max, so ties resolve to the lowest index.
  - After idx NCH-1: o_best updated, o_best_valid pulses 1 cycle, return to IDLE. Result appears NCH cycles after o_valid.
  - A new o_valid during SCAN aborts and restarts the scan at idx 0 on the new data; no o_best_valid for the aborted scan.
- All-zero frame: o_best=0, o_best_valid still pulses.
- Reset asserted mid-frame or mid-scan: immediate clear per reset values; no valid pulses until after a subsequent vs_fall.
- First vs_fall after reset produces a valid frame result (partial frame counts as-is).

Decomposition:
- Package area_stats_pkg: default widths, the POL constant, and a function returning clog2(NCH) with a minimum of 1.
- Sub-module area_cnt_ch: one channel's saturating accumulator plus sticky sat flag, with inputs inc, clr, and outputs cnt, sat.
  - The top instantiates NCH of them via generate and owns the coordinates, ROI, latch and FSM.

Test Plan:
- NCH=4, POL=0, 8x4 frame, full ROI; ch0 mask all 0, ch1 alternating, ch2 all 1, ch3 zeros only on row 2 -> o_area={8,0,16,32} (ch3..ch0), o_valid 1 cycle after vs_fall, o_best=0 after 4 more cycles.
- ROI x=2..5, y=1..2 programmed during frame 1, all masks 0 -> frame 1 counts 32/ch; frame 2 counts 8/ch. ROI x0=6,x1=2 -> 0.
- CNT_W=4, 20 qualifying pixels on ch1 -> o_area ch1=15, o_sat=4'b0010; next frame with 3 pixels -> 3, o_sat=0.
- Tie: ch1=ch3=10, others 5 -> o_best=1. en low for whole frame -> all 0, o_best=0, both valid pulses present.
- Qualifying pixel coincident with vs_fall is included in the closing frame. Two vs_falls 2 cycles apart -> scan restarts, single o_best_valid.
- rst_n low mid-frame and mid-SCAN -> all outputs 0 immediately, no o_best_valid; recovery on the next frame.
